// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: datapath widths, memory-access FSM states and
// the EX/MEM pipeline register layout.
package cpu_pkg;

    localparam int DATA_W   = 16;
    localparam int REG_AW   = 4;
    localparam int MAX_WAIT = 15;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] store;
        logic [REG_AW-1:0] dst;
        logic              rd;
        logic              wr;
        logic              rw;
    } exmem_t;

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory handshake sequencer: raises req for the access held in EX/MEM,
// waits for ack, and gives up with a one-cycle error after MAX_WAIT cycles.
module mem_access_fsm
    import cpu_pkg::*;
#(
    parameter int MAX_WAIT = cpu_pkg::MAX_WAIT
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic ack,
    output logic req,
    output logic done,
    output logic timeout,
    output logic mem_err
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    mem_state_t    state;
    mem_state_t    state_nxt;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            mem_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= (state == WAIT && state_nxt == WAIT) ? cnt + 1'b1 : '0;
            mem_err <= timeout;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = WAIT;
            WAIT: if (ack || cnt == CW'(MAX_WAIT - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ack in the last permitted cycle still completes the access
    always_comb begin
        req     = (state == WAIT);
        done    = (state == WAIT) && ack;
        timeout = (state == WAIT) && !ack && (cnt == CW'(MAX_WAIT - 1));
    end

endmodule

// File: rtl/cpu_mem_stage.sv
// MEM pipeline stage: EX/MEM register, multi-cycle data-memory access,
// MEM/WB register, upstream stall and EX/MEM + MEM/WB forwarding.
module cpu_mem_stage #(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int REG_AW   = cpu_pkg::REG_AW,
    parameter int MAX_WAIT = cpu_pkg::MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_alu_out,
    input  logic [REG_AW-1:0] ex_reg_w,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_reg_write,
    input  logic              flush,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall,
    output logic              mem_err,
    output logic              fwd_em_valid,
    output logic [REG_AW-1:0] fwd_em_reg,
    output logic [DATA_W-1:0] fwd_em_data,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_reg_w,
    output logic [DATA_W-1:0] wb_data
);

    import cpu_pkg::*;

    exmem_t            em_p0;
    logic              wb_valid_p1;
    logic [REG_AW-1:0] wb_reg_p1;
    logic [DATA_W-1:0] wb_data_p1;

    logic start;
    logic req;
    logic done;
    logic timeout;

    assign start = em_p0.valid & (em_p0.rd | em_p0.wr);
    // the memory op stays in EX/MEM from capture until ack or timeout
    assign stall = start & ~done;

    mem_access_fsm #(
        .MAX_WAIT(MAX_WAIT)
    ) u_fsm (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .ack     (mem_ack),
        .req     (req),
        .done    (done),
        .timeout (timeout),
        .mem_err (mem_err)
    );

    assign mem_req   = req;
    assign mem_we    = req & em_p0.wr;
    assign mem_addr  = req ? em_p0.alu   : '0;
    assign mem_wdata = req ? em_p0.store : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            em_p0       <= '0;
            wb_valid_p1 <= 1'b0;
            wb_reg_p1   <= '0;
            wb_data_p1  <= '0;
        end else begin
            // EX -> EX/MEM
            if (timeout) begin
                em_p0.valid <= 1'b0;
            end else if (!stall) begin
                em_p0 <= '{valid: ex_valid & ~flush, alu: ex_alu_out,
                           store: ex_store_data, dst: ex_reg_w,
                           rd: ex_mem_read, wr: ex_mem_write, rw: ex_reg_write};
            end
            // EX/MEM -> MEM/WB
            if (stall) begin
                wb_valid_p1 <= 1'b0;
            end else begin
                wb_valid_p1 <= em_p0.valid & em_p0.rw & ~em_p0.wr & (em_p0.dst != '0);
                wb_reg_p1   <= em_p0.dst;
                wb_data_p1  <= em_p0.rd ? mem_rdata : em_p0.alu;
            end
        end
    end

    assign fwd_em_valid = em_p0.valid & em_p0.rw & ~em_p0.rd & ~em_p0.wr & (em_p0.dst != '0);
    assign fwd_em_reg   = em_p0.dst;
    assign fwd_em_data  = em_p0.alu;

    assign wb_valid = wb_valid_p1;
    assign wb_reg_w = wb_reg_p1;
    assign wb_data  = wb_data_p1;

endmodule

// File: tb/tb_cpu_mem_stage.sv
// Directed bench for cpu_mem_stage: ALU pass-through, load/store handshakes,
// R0 suppression, flush, timeout and reset during a pending access.
module tb_cpu_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [15:0] ex_alu_out;
    logic [3:0]  ex_reg_w;
    logic [15:0] ex_store_data;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_reg_write;
    logic        flush;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic        mem_err;
    logic        fwd_em_valid;
    logic [3:0]  fwd_em_reg;
    logic [15:0] fwd_em_data;
    logic        wb_valid;
    logic [3:0]  wb_reg_w;
    logic [15:0] wb_data;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cpu_mem_stage dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_alu_out    (ex_alu_out),
        .ex_reg_w      (ex_reg_w),
        .ex_store_data (ex_store_data),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_reg_write  (ex_reg_write),
        .flush         (flush),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .stall         (stall),
        .mem_err       (mem_err),
        .fwd_em_valid  (fwd_em_valid),
        .fwd_em_reg    (fwd_em_reg),
        .fwd_em_data   (fwd_em_data),
        .wb_valid      (wb_valid),
        .wb_reg_w      (wb_reg_w),
        .wb_data       (wb_data)
    );

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        ex_valid      = 1'b0;
        ex_alu_out    = '0;
        ex_reg_w      = '0;
        ex_store_data = '0;
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b0;
        ex_reg_write  = 1'b0;
        flush         = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        clear_ex();
        tick();
        tick();
        chk("rst_req",   32'(mem_req), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_err",   32'(mem_err), 0);
        chk("rst_fwd",   32'(fwd_em_valid), 0);
        chk("rst_wbv",   32'(wb_valid), 0);
        chk("rst_wbd",   32'(wb_data), 0);
        rst = 1'b0;

        // ALU op R3 <- 0x1234
        ex_valid = 1'b1; ex_alu_out = 16'h1234; ex_reg_w = 4'd3; ex_reg_write = 1'b1;
        #1 chk("alu_stall0", 32'(stall), 0);
        tick();
        clear_ex();
        chk("alu_fwdv", 32'(fwd_em_valid), 1);
        chk("alu_fwdr", 32'(fwd_em_reg), 3);
        chk("alu_fwdd", 32'(fwd_em_data), 32'h1234);
        chk("alu_stall1", 32'(stall), 0);
        tick();
        chk("alu_wbv", 32'(wb_valid), 1);
        chk("alu_wbr", 32'(wb_reg_w), 3);
        chk("alu_wbd", 32'(wb_data), 32'h1234);
        chk("alu_stall2", 32'(stall), 0);

        // load R5 <- [0x0040], ack in third request cycle, flush raised meanwhile
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_alu_out = 16'h0040; ex_reg_w = 4'd5; ex_reg_write = 1'b1;
        tick();
        clear_ex();
        chk("ld_stall_a", 32'(stall), 1);
        chk("ld_req_a",   32'(mem_req), 0);
        chk("ld_fwdv",    32'(fwd_em_valid), 0);
        tick();
        chk("ld_req_b",  32'(mem_req), 1);
        chk("ld_we_b",   32'(mem_we), 0);
        chk("ld_addr_b", 32'(mem_addr), 32'h0040);
        chk("ld_stall_b", 32'(stall), 1);
        ex_valid = 1'b1; flush = 1'b1; ex_alu_out = 16'h5555; ex_reg_w = 4'd7; ex_reg_write = 1'b1;
        tick();
        chk("ld_req_c",   32'(mem_req), 1);
        chk("ld_stall_c", 32'(stall), 1);
        chk("ld_wbv_c",   32'(wb_valid), 0);
        tick();
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        #1;
        chk("ld_req_d",   32'(mem_req), 1);
        chk("ld_stall_d", 32'(stall), 0);
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        clear_ex();
        chk("ld_req_e", 32'(mem_req), 0);
        chk("ld_wbv",   32'(wb_valid), 1);
        chk("ld_wbr",   32'(wb_reg_w), 5);
        chk("ld_wbd",   32'(wb_data), 32'hBEEF);
        chk("flushw_fwdv", 32'(fwd_em_valid), 0);

        // store 0x00FF -> [0x0010], ack in first request cycle
        ex_valid = 1'b1; ex_mem_write = 1'b1; ex_alu_out = 16'h0010; ex_store_data = 16'h00FF;
        tick();
        clear_ex();
        chk("st_stall_a", 32'(stall), 1);
        chk("st_req_a",   32'(mem_req), 0);
        tick();
        mem_ack = 1'b1;
        #1;
        chk("st_req",   32'(mem_req), 1);
        chk("st_we",    32'(mem_we), 1);
        chk("st_addr",  32'(mem_addr), 32'h0010);
        chk("st_wdata", 32'(mem_wdata), 32'h00FF);
        chk("st_stall", 32'(stall), 0);
        tick();
        mem_ack = 1'b0;
        chk("st_req_e", 32'(mem_req), 0);
        chk("st_we_e",  32'(mem_we), 0);
        chk("st_wbv",   32'(wb_valid), 0);

        // write to R0
        ex_valid = 1'b1; ex_alu_out = 16'h9999; ex_reg_w = 4'd0; ex_reg_write = 1'b1;
        tick();
        clear_ex();
        chk("r0_fwdv", 32'(fwd_em_valid), 0);
        tick();
        chk("r0_wbv", 32'(wb_valid), 0);

        // flushed instruction becomes a bubble
        ex_valid = 1'b1; flush = 1'b1; ex_alu_out = 16'h4321; ex_reg_w = 4'd2; ex_reg_write = 1'b1;
        tick();
        clear_ex();
        chk("fl_fwdv", 32'(fwd_em_valid), 0);
        tick();
        chk("fl_wbv", 32'(wb_valid), 0);

        // load that never gets acked: 15 request cycles then error
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_alu_out = 16'h0080; ex_reg_w = 4'd6; ex_reg_write = 1'b1;
        tick();
        clear_ex();
        tick();
        chk("to_req_1", 32'(mem_req), 1);
        for (int i = 0; i < 14; i++) begin
            tick();
            chk("to_req_n", 32'(mem_req), 1);
            chk("to_err_n", 32'(mem_err), 0);
        end
        tick();
        chk("to_err",   32'(mem_err), 1);
        chk("to_req",   32'(mem_req), 0);
        chk("to_stall", 32'(stall), 0);
        chk("to_wbv",   32'(wb_valid), 0);
        tick();
        chk("to_err_e",   32'(mem_err), 0);
        chk("to_req_e",   32'(mem_req), 0);
        chk("to_stall_e", 32'(stall), 0);
        chk("to_wbv_e",   32'(wb_valid), 0);

        // reset while waiting, then a late ack
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_alu_out = 16'h0020; ex_reg_w = 4'd4; ex_reg_write = 1'b1;
        tick();
        clear_ex();
        tick();
        chk("rw_req", 32'(mem_req), 1);
        rst = 1'b1;
        tick();
        chk("rw_req_r",   32'(mem_req), 0);
        chk("rw_stall_r", 32'(stall), 0);
        chk("rw_addr_r",  32'(mem_addr), 0);
        chk("rw_wbv_r",   32'(wb_valid), 0);
        chk("rw_wbd_r",   32'(wb_data), 0);
        chk("rw_fwdd_r",  32'(fwd_em_data), 0);
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        tick();
        mem_ack = 1'b0;
        chk("rw_late_wbv", 32'(wb_valid), 0);
        chk("rw_late_req", 32'(mem_req), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
